ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 byte deserializer; consumes its 8-bit scan code and one-cycle byte strobe.
- Interprets PS/2 Set-2 prefixes (E0 extended, F0 break, E1 Pause sequence) and discards protocol bytes.
- Optionally filters typematic repeats.
- Queues clean key events {ext, break, code} in a small FIFO that the step sequencer's input logic drains with valid/ready.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 2500000, cycles without a byte, while a prefix is pending, before the decoder abandons the partial sequence (50 ms at 50 MHz).
- FILTER_REPEAT, 1, when 1, suppress a make identical to the last accepted make if no break for that key has arrived in between.

Ports:
- CLOCK_50  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- byte_data  in  8  received scan-code byte
- byte_valid  in  1  one-cycle strobe; byte_data is valid in that cycle
- evt_code  out  8  head event scan code
- evt_ext  out  1  head event was E0-prefixed
- evt_break  out  1  head event is a release (1) or a press (0)
- evt_valid  out  1  FIFO not empty
- evt_ready  in  1  consumer pops the head when evt_valid=1 and evt_ready=1
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full

Behaviour:
- Reset (async, active-high): FSM=IDLE, FIFO empty, timeout counter=0, last-make invalid. All outputs 0; evt_code/evt_ext/evt_break are forced to 0 whenever the FIFO is empty.
- Bytes are processed only in cycles with byte_valid=1. Ignored bytes: 00, AA, EE, FA, FE, FF. In IDLE these are dropped. In any prefix state they return the FSM to IDLE with no event.
- IDLE:
  - E0 -> EXT
  - F0 -> BRK
  - E1 -> SKIP, skip counter=7
  - any other byte -> emit make {ext=0}
- EXT:
  - F0 -> EXT_BRK
  - 12 or 59 (fake shift) -> IDLE, no event
  - E0 -> stay
  - other -> emit make {ext=1}, go to IDLE
- BRK:
  - F0 or E0 -> stay
  - other -> emit break {ext=0}, go to IDLE
- EXT_BRK:
  - 12 or 59 -> IDLE, no event
  - other -> emit break {ext=1}, go to IDLE
- SKIP: each byte decrements the skip counter; the byte that takes it from 1 to 0 returns the FSM to IDLE. No event is emitted for any byte of the Pause sequence.
- Timeout: the counter clears on every byte_valid and increments every cycle while the FSM is not IDLE. At TIMEOUT_CYCLES-1 the FSM goes to IDLE and the counter clears. The abandoned prefix emits nothing.
- Repeat filter (FILTER_REPEAT=1):
  - A make equal to last_make {ext, code} while last_make is valid is dropped.
  - Every accepted make loads last_make.
  - A break matching last_make invalidates it.
  - Breaks are never filtered.
- Latency: emission is decided in the cycle of byte_valid and written at that clock edge; evt_valid and the event fields are visible on the next cycle (1-cycle latency).
- FIFO: first-word fall-through. Order is preserved.
  - A push when full with no pop in the same cycle drops the new event, sets overflow, and leaves the contents unchanged.
  - A push and pop in the same cycle when full are both accepted; count is unchanged.
  - A push and pop in the same cycle when empty: the pop is not honoured (evt_valid=0) and the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on Reset.
- Reset mid-sequence discards the pending prefix and all queued events.

Decomposition:
- Package ps2_pkg:
  - byte constants: E0, F0, E1, 12, 59, AA, EE, FA, FE, 00, FF
  - decoder state enum: IDLE, EXT, BRK, EXT_BRK, SKIP
  - packed key_event_t {ext, brk, code[7:0]}
  - PAUSE_TAIL_LEN = 7
- Sub-module key_event_fifo: parameterised FWFT FIFO with count and a full-drop indication. Prefix FSM, timeout and repeat filter stay in ps2_key_decoder.

Test Plan:
- Byte 1C with evt_ready=1 -> next cycle evt_valid=1, code=1C, ext=0, break=0, popped the same cycle. Then F0,1C -> exactly one event, code=1C, break=1.
- E0,75 then E0,F0,75 -> make {ext=1, 75} then break {ext=1, 75}. E0,12,E0,75 -> only make {ext=1, 75}. AA and FA alone -> no events.
- E1,14,77,E1,F0,14,F0,77 then 1C -> exactly one event, make 1C. fifo_count stays 0 throughout the Pause bytes.
- FILTER_REPEAT=1: 1C,1C,1C,F0,1C,1C -> events: make 1C, break 1C, make 1C (three total).
- evt_ready=0, FIFO_DEPTH=4, makes 15,1D,24,2D,2C -> fifo_count=4, overflow=1; draining yields 15,1D,24,2D. Then a push while full with a simultaneous pop is accepted and count stays 4.
- Byte F0, idle TIMEOUT_CYCLES cycles, then 1C -> make 1C (not break). Reset asserted after E0 with 2 queued events -> evt_valid=0, fifo_count=0, next 75 -> make {ext=0, 75}.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 Set-2 byte constants, decoder states and key event type
package ps2_pkg;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_59 = 8'h59;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;
  localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} dec_state_t;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {SC_00, SC_AA, SC_EE, SC_FA, SC_FE, SC_FF};
  endfunction
  function automatic logic is_fake_shift(input logic [7:0] b);
    return b == SC_12 || b == SC_59;
  endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: first-word fall-through key event queue with occupancy and full-drop flag
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               CLOCK_50,
  input  logic               Reset,
  input  logic               push,
  input  key_event_t         push_evt,
  input  logic               pop,
  output key_event_t         head_evt,
  output logic               head_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic               drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  key_event_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign head_valid = count != '0;
  assign head_evt = head_valid ? mem[rd_ptr] : '0;
  assign do_pop = pop && head_valid;
  assign do_push = push && (count != FULL || do_pop);
  assign drop = push && !do_push;
  // event storage; contents are only observed once written
  always_ff @(posedge CLOCK_50)
    if (do_push) mem[wr_ptr] <= push_evt;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge CLOCK_50 or posedge Reset)
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 Set-2 scan bytes into queued {ext, break, code} key events
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic                         CLOCK_50,
  input  logic                         Reset,
  input  logic [7:0]                   byte_data,
  input  logic                         byte_valid,
  output logic [7:0]                   evt_code,
  output logic                         evt_ext,
  output logic                         evt_break,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  dec_state_t state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [8:0] last_make;
  logic last_valid;
  logic emit, match, push, drop;
  key_event_t emit_evt, head;
  assign emit_evt = '{ext: state == EXT || state == EXT_BRK, brk: state == BRK || state == EXT_BRK, code: byte_data};
  // next prefix state and whether the current byte completes a key event
  always_comb begin
    state_nxt = state;
    skip_nxt = skip_cnt;
    emit = 1'b0;
    if (byte_valid) begin
      if (is_ignored(byte_data)) state_nxt = IDLE;
      else
        case (state)
          IDLE: begin
            if (byte_data == SC_E0) state_nxt = EXT;
            else if (byte_data == SC_F0) state_nxt = BRK;
            else if (byte_data == SC_E1) begin
              state_nxt = SKIP;
              skip_nxt = PAUSE_TAIL_LEN;
            end else emit = 1'b1;
          end
          EXT: begin
            if (byte_data == SC_F0) state_nxt = EXT_BRK;
            else if (byte_data != SC_E0) begin
              state_nxt = IDLE;
              emit = !is_fake_shift(byte_data);
            end
          end
          BRK: begin
            if (byte_data != SC_F0 && byte_data != SC_E0) begin
              state_nxt = IDLE;
              emit = 1'b1;
            end
          end
          EXT_BRK: begin
            state_nxt = IDLE;
            emit = !is_fake_shift(byte_data);
          end
          SKIP: begin
            skip_nxt = skip_cnt - 1'b1;
            state_nxt = skip_cnt == 3'd1 ? IDLE : SKIP;
          end
          default: state_nxt = IDLE;
        endcase
    end
  end
  assign match = last_valid && last_make == {emit_evt.ext, emit_evt.code};
  assign push = emit && !(FILTER_REPEAT && !emit_evt.brk && match);
  // prefix FSM, pause skipping, stale-prefix timeout and last-make memory
  always_ff @(posedge CLOCK_50 or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      skip_cnt <= '0;
      tmo_cnt <= '0;
      last_make <= '0;
      last_valid <= 1'b0;
    end else begin
      if (byte_valid) begin
        state <= state_nxt;
        skip_cnt <= skip_nxt;
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          state <= IDLE;
          tmo_cnt <= '0;
        end else tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (push && !emit_evt.brk) begin
        last_make <= {emit_evt.ext, emit_evt.code};
        last_valid <= 1'b1;
      end else if (emit && emit_evt.brk && match) last_valid <= 1'b0;
    end
  // sticky record of any event lost to a full queue
  always_ff @(posedge CLOCK_50 or posedge Reset)
    if (Reset) overflow <= 1'b0;
    else overflow <= overflow | drop;
  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK_50(CLOCK_50),
    .Reset(Reset),
    .push(push),
    .push_evt(emit_evt),
    .pop(evt_ready),
    .head_evt(head),
    .head_valid(evt_valid),
    .count(fifo_count),
    .drop(drop)
  );
  assign evt_code = head.code;
  assign evt_ext = head.ext;
  assign evt_break = head.brk;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and randomized checks against a queue-based protocol model
module tb_ps2_key_decoder;
  localparam int DEPTH = 4;
  localparam int T = 20;
  logic CLOCK_50 = 1'b0;
  logic Reset = 1'b1;
  logic byte_valid = 1'b0;
  logic evt_ready = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic [7:0] evt_code;
  logic evt_ext, evt_break, evt_valid, overflow;
  logic [$clog2(DEPTH):0] fifo_count;
  int checks = 0;
  int failures = 0;
  logic [9:0] q[$];
  logic [9:0] popped[$];
  bit ext_p, brk_p, lm_valid, ovf;
  int skip_left, idle_n, m;
  logic [8:0] lm;
  logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'hFA, 8'h00,
                            8'h1C, 8'h1C, 8'h75, 8'h75, 8'h15, 8'hF0, 8'hE0, 8'h14};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T), .FILTER_REPEAT(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void clear_prefix();
    ext_p = 1'b0;
    brk_p = 1'b0;
    skip_left = 0;
  endfunction

  function automatic void emit(input bit e, input bit b, input logic [7:0] c);
    if (!b && lm_valid && lm == {e, c}) return;
    if (!b) begin
      lm = {e, c};
      lm_valid = 1'b1;
    end else if (lm_valid && lm == {e, c}) lm_valid = 1'b0;
    if (q.size() < DEPTH) q.push_back({e, b, c});
    else ovf = 1'b1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit ign = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    bit fake = b == 8'h12 || b == 8'h59;
    if (ign) begin
      clear_prefix();
      return;
    end
    if (skip_left > 0) begin
      skip_left--;
      return;
    end
    if (!ext_p && !brk_p) begin
      if (b == 8'hE0) ext_p = 1'b1;
      else if (b == 8'hF0) brk_p = 1'b1;
      else if (b == 8'hE1) skip_left = 7;
      else emit(1'b0, 1'b0, b);
    end else if (ext_p && !brk_p) begin
      if (b == 8'hF0) brk_p = 1'b1;
      else if (b != 8'hE0) begin
        if (!fake) emit(1'b1, 1'b0, b);
        clear_prefix();
      end
    end else if (!ext_p) begin
      if (b != 8'hF0 && b != 8'hE0) begin
        emit(1'b0, 1'b1, b);
        clear_prefix();
      end
    end else begin
      if (!fake) emit(1'b1, 1'b1, b);
      clear_prefix();
    end
  endfunction

  task automatic tick(input logic v, input logic [7:0] b, input logic r);
    @(negedge CLOCK_50);
    chk("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("head_event", 32'({evt_ext, evt_break, evt_code}), 32'(q.size() != 0 ? q[0] : 10'h000));
    byte_valid = v;
    byte_data = b;
    evt_ready = r;
    if (r && q.size() != 0) popped.push_back(q.pop_front());
    if (v) begin
      idle_n = 0;
      model_byte(b);
    end else if (ext_p || brk_p || skip_left > 0) begin
      idle_n++;
      if (idle_n == T) clear_prefix();
    end
    @(posedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b, input logic r);
    tick(1'b1, b, r);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, r);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    byte_valid = 1'b0;
    Reset = 1'b1;
    #1;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_event", 32'({evt_ext, evt_break, evt_code}), 32'd0);
    q.delete();
    clear_prefix();
    lm_valid = 1'b0;
    ovf = 1'b0;
    idle_n = 0;
    @(negedge CLOCK_50);
    Reset = 1'b0;
  endtask

  task automatic expect_pops(input string tag, input int mark, input int n, input logic [39:0] e);
    chk({tag, "_n"}, 32'(popped.size() - mark), 32'(n));
    for (int i = 0; i < n; i++)
      if (mark + i < popped.size()) chk(tag, 32'(popped[mark + i]), 32'(e[39 - 10*i -: 10]));
  endtask

  initial begin
    clear_prefix();
    do_reset();
    m = popped.size(); send(8'h1C, 1'b1); idle(2, 1'b1);
    expect_pops("make_1c", m, 1, {10'h01C, 30'h0});
    m = popped.size(); send(8'hF0, 1'b1); send(8'h1C, 1'b1); idle(2, 1'b1);
    expect_pops("break_1c", m, 1, {10'h11C, 30'h0});
    m = popped.size();
    send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1); idle(2, 1'b1);
    expect_pops("repeat", m, 3, {10'h01C, 10'h11C, 10'h01C, 10'h0});
    m = popped.size();
    send(8'hE0, 1'b1); send(8'h75, 1'b1); send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1); idle(2, 1'b1);
    expect_pops("ext", m, 2, {10'h275, 10'h375, 20'h0});
    m = popped.size();
    send(8'hE0, 1'b1); send(8'h12, 1'b1); send(8'hE0, 1'b1); send(8'h75, 1'b1); idle(2, 1'b1);
    expect_pops("fake_shift", m, 1, {10'h275, 30'h0});
    m = popped.size(); send(8'hAA, 1'b1); send(8'hFA, 1'b1); idle(2, 1'b1);
    expect_pops("ignored", m, 0, 40'h0);
    m = popped.size();
    foreach (pause_seq[i]) send(pause_seq[i], 1'b1);
    send(8'h1C, 1'b1); idle(2, 1'b1);
    expect_pops("pause", m, 1, {10'h01C, 30'h0});
    send(8'h15, 1'b0); send(8'h1D, 1'b0); send(8'h24, 1'b0); send(8'h2D, 1'b0); send(8'h2C, 1'b0);
    idle(1, 1'b0); #1;
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_overflow", 32'(overflow), 32'd1);
    m = popped.size(); idle(6, 1'b1);
    expect_pops("drain", m, 4, {10'h015, 10'h01D, 10'h024, 10'h02D});
    send(8'h35, 1'b0); send(8'h3C, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b0);
    m = popped.size(); send(8'h4B, 1'b1); idle(1, 1'b0); #1;
    chk("full_push_pop_count", 32'(fifo_count), 32'd4);
    expect_pops("full_push_pop", m, 1, {10'h035, 30'h0});
    m = popped.size(); idle(6, 1'b1);
    expect_pops("drain2", m, 4, {10'h03C, 10'h043, 10'h044, 10'h04B});
    m = popped.size(); send(8'hF0, 1'b1); idle(T, 1'b1); send(8'h1C, 1'b1); idle(2, 1'b1);
    expect_pops("timeout", m, 1, {10'h01C, 30'h0});
    m = popped.size(); send(8'hF0, 1'b1); idle(T - 2, 1'b1); send(8'h1C, 1'b1); idle(2, 1'b1);
    expect_pops("no_timeout", m, 1, {10'h11C, 30'h0});
    send(8'h15, 1'b0); send(8'h1D, 1'b0); send(8'hE0, 1'b0);
    do_reset();
    m = popped.size(); send(8'h75, 1'b1); idle(2, 1'b1);
    expect_pops("post_reset", m, 1, {10'h075, 30'h0});
    for (int i = 0; i < 4000; i++) begin
      logic v, r;
      if (i % 1000 == 999) do_reset();
      v = (i >= 2000 && i < 3000) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
      r = (i % 400 < 100) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick(v, pool[$urandom_range(0, 15)], r);
    end
    idle(8, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
